polar_frame_sequencer: RTL and testbench
========================================

# polar_frame_sequencer

Top-level frame sequencer for the polar decoder: it owns the one-hot `state` bus that the input, decode and output blocks decode, and it steps one frame at a time through input load, decode, output settle and AXI-Stream output. It counts input handshakes, launches and supervises the decoder core, and watches the output stream handshakes to detect end of frame. It also keeps a completed-frame counter and sticky error flags for software.

## Interface
- STATE_WIDTH, 10, width of `state` bus
- IDLE_STATE, 10'd1, code for idle
- INPUT_STATE, 10'd2, code for input load
- DECODE_START_STATE, 10'd4, code for the one-cycle decoder launch
- DECODE_STATE, 10'd8, code for waiting on the decoder
- OUTPUT_WAIT_STATE, 10'd256, code for output-buffer settle
- OUTPUT_STATE, 10'd512, code for streaming output
- INPUT_LENGTH, 1024, input beats per frame
- CNT_WIDTH, 11, width of the input beat counter; must be able to hold INPUT_LENGTH
- OUTPUT_WAIT_CYCLES, 2, cycles spent in OUTPUT_WAIT_STATE; minimum 1
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in DECODE_STATE
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  level signal; while high, frames run back to back
- err_clear  in  1  one-cycle pulse that clears both error flags
- saxis_tvalid  in  1  input stream valid (observed)
- saxis_tlast  in  1  input stream last (observed)
- saxis_tready  out  1  input stream ready
- decode_start  out  1  one-cycle launch pulse to the decoder core
- decode_done  in  1  decoder completion pulse or level
- maxis_tvalid, maxis_tready, maxis_tlast  in  1 each  output stream signals (monitored only)
- state  out  STATE_WIDTH  current state code (registered)
- busy  out  1  high whenever `state` is not IDLE_STATE
- frame_count  out  16  number of frames completed; wraps from 0xFFFF to 0
- err_tlast  out  1  sticky: input tlast was misplaced
- err_timeout  out  1  sticky: the decoder timed out

## Operation
- Reset values: `state` = IDLE_STATE; all counters = 0; `saxis_tready`, `decode_start`, `busy`, `err_tlast` and `err_timeout` = 0.
- IDLE -> INPUT when `enable` = 1.
- INPUT:
  - `saxis_tready` = 1.
  - Each cycle with tvalid & tready increments the beat counter.
  - The accepted beat with count == INPUT_LENGTH-1 moves the block to DECODE_START and clears the counter.
  - `err_tlast` sets if `saxis_tlast` is high on any other accepted beat, or low on the final beat. The frame length stays INPUT_LENGTH regardless of tlast.
- DECODE_START: `decode_start` = 1 for exactly this one cycle, then DECODE. `decode_done` is ignored in this state.
- DECODE:
  - The timeout counter starts at 0 on entry and increments every cycle.
  - `decode_done` = 1 moves the block to OUTPUT_WAIT.
  - If the counter reaches TIMEOUT_CYCLES-1 with no `decode_done`: set `err_timeout` and go to IDLE. The frame is dropped and `frame_count` is unchanged.
  - If `decode_done` arrives on that same last cycle, done wins.
- OUTPUT_WAIT: stay exactly OUTPUT_WAIT_CYCLES cycles, then OUTPUT.
- OUTPUT:
  - Exit on a cycle with `maxis_tvalid` & `maxis_tready` & `maxis_tlast` all high.
  - On exit, increment `frame_count`, then go to INPUT if `enable` = 1, else IDLE.
  - No timeout applies; back-pressure may hold this state indefinitely.
- Dropping `enable` mid-frame does not abort the frame; it only blocks the next one.
- `err_clear` clears both flags. If a set and `err_clear` occur in the same cycle, the set wins.
- Asserting `reset` in any state returns every output to its reset value on the next edge, including the error flags and `frame_count`.

## Timing
- `state` is a register. `saxis_tready`, `decode_start` and `busy` are decoded from the state register only, with no combinational path from any input.
- Every transition takes effect on the edge that samples its qualifying condition, so `state` changes in the following cycle.
- Minimum frame length in cycles: INPUT_LENGTH + 1 (DECODE_START) + decode time + OUTPUT_WAIT_CYCLES + output beats.
- The decoder sees `decode_start` exactly one cycle after the final input beat is accepted.

## Test plan
- Reset, then `enable`=1, 1024 beats with tlast on beat 1023, `decode_done` 10 cycles after `decode_start`, one output tlast handshake:
  - required: state sequence 1,2,4,8,256,256,512,2;
  - required: `frame_count`=1, both error flags 0.
- tlast on beat 500 of 1024:
  - required: `err_tlast`=1 after beat 500;
  - required: DECODE_START is still entered only after beat 1023.
- No `decode_done`, TIMEOUT_CYCLES=16:
  - required: after 16 cycles in DECODE, `err_timeout`=1 and state returns to 1;
  - required: `frame_count` stays 0.
- `maxis_tready`=0 for 50 cycles during OUTPUT:
  - required: state stays 512 throughout;
  - required: tvalid & tlast without tready does not end the frame.
- `enable` dropped during DECODE: the current frame completes, then state goes to 1 and `frame_count` increments by 1.
- `reset` pulsed during INPUT after 300 beats, then a full frame:
  - required: all outputs return to their reset values;
  - required: the next frame needs the full 1024 beats;
  - required: an `err_clear` in the same cycle as an error set leaves the flag at 1.

Source files
------------

// File: rtl/polar_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the input stream,
// the decoder core and the monitored output stream.
interface polar_frame_sequencer_if;
  logic saxis_tvalid;
  logic saxis_tlast;
  logic saxis_tready;
  logic decode_start;
  logic decode_done;
  logic maxis_tvalid;
  logic maxis_tready;
  logic maxis_tlast;

  modport master (
    output saxis_tvalid, saxis_tlast, decode_done,
           maxis_tvalid, maxis_tready, maxis_tlast,
    input  saxis_tready, decode_start
  );

  modport slave (
    input  saxis_tvalid, saxis_tlast, decode_done,
           maxis_tvalid, maxis_tready, maxis_tlast,
    output saxis_tready, decode_start
  );
endinterface

// File: rtl/polar_frame_sequencer.sv
// Polar decoder frame sequencer: steps each frame through input load, decoder
// launch/supervision, output settle and output streaming, with sticky errors.
module polar_frame_sequencer #(
  parameter int                        STATE_WIDTH        = 10,
  parameter logic [STATE_WIDTH-1:0]    IDLE_STATE         = 10'd1,
  parameter logic [STATE_WIDTH-1:0]    INPUT_STATE        = 10'd2,
  parameter logic [STATE_WIDTH-1:0]    DECODE_START_STATE = 10'd4,
  parameter logic [STATE_WIDTH-1:0]    DECODE_STATE       = 10'd8,
  parameter logic [STATE_WIDTH-1:0]    OUTPUT_WAIT_STATE  = 10'd256,
  parameter logic [STATE_WIDTH-1:0]    OUTPUT_STATE       = 10'd512,
  parameter int                        INPUT_LENGTH       = 1024,
  parameter int                        CNT_WIDTH          = 11,
  parameter int                        OUTPUT_WAIT_CYCLES = 2,
  parameter int                        TIMEOUT_CYCLES     = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   err_clear,
  polar_frame_sequencer_if.slave bus,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic                   err_tlast,
  output logic                   err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WW = (OUTPUT_WAIT_CYCLES > 2) ? $clog2(OUTPUT_WAIT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT    = CNT_WIDTH'(INPUT_LENGTH - 1);
  localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0]        WAIT_LAST    = WW'(OUTPUT_WAIT_CYCLES - 1);

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE         = IDLE_STATE,
    ST_INPUT        = INPUT_STATE,
    ST_DECODE_START = DECODE_START_STATE,
    ST_DECODE       = DECODE_STATE,
    ST_OUTPUT_WAIT  = OUTPUT_WAIT_STATE,
    ST_OUTPUT       = OUTPUT_STATE
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [TW-1:0]        timeout_cnt;
  logic [WW-1:0]        wait_cnt;

  // Error sets are written after the clear so that a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt    <= '0;
      timeout_cnt <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
      err_tlast   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (err_clear) begin
        err_tlast   <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_INPUT;
        end
        ST_INPUT: begin
          if (bus.saxis_tvalid && bus.saxis_tready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state_q  <= ST_DECODE_START;
              if (!bus.saxis_tlast) err_tlast <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (bus.saxis_tlast) err_tlast <= 1'b1;
            end
          end
        end
        ST_DECODE_START: begin
          timeout_cnt <= '0;
          state_q     <= ST_DECODE;
        end
        ST_DECODE: begin
          if (bus.decode_done) begin
            wait_cnt <= '0;
            state_q  <= ST_OUTPUT_WAIT;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ST_OUTPUT_WAIT: begin
          if (wait_cnt == WAIT_LAST) state_q <= ST_OUTPUT;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        ST_OUTPUT: begin
          if (bus.maxis_tvalid && bus.maxis_tready && bus.maxis_tlast) begin
            frame_count <= frame_count + 16'd1;
            state_q     <= enable ? ST_INPUT : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state            = state_q;
  assign busy             = (state_q != ST_IDLE);
  assign bus.saxis_tready = (state_q == ST_INPUT);
  assign bus.decode_start = (state_q == ST_DECODE_START);

endmodule

// File: tb/tb_polar_frame_sequencer.sv
// Directed bench for polar_frame_sequencer: normal frame, misplaced tlast,
// decoder timeout, output back-pressure, enable drop and mid-frame reset.
module tb_polar_frame_sequencer;
  localparam int LEN = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        err_clear;
  logic [9:0]  state;
  logic        busy;
  logic [15:0] frame_count;
  logic        err_tlast;
  logic        err_timeout;

  int check_count = 0;
  int pass_count  = 0;

  polar_frame_sequencer_if bus ();

  polar_frame_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .err_clear   (err_clear),
    .bus         (bus),
    .state       (state),
    .busy        (busy),
    .frame_count (frame_count),
    .err_tlast   (err_tlast),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Drives n_beats input beats from INPUT; optional idle gaps every 256 beats.
  task automatic applyStimulus(input int n_beats, input int tlast_pos,
                               input int clear_at, input bit gaps);
    int bad = 0;
    for (int i = 0; i < n_beats; i++) begin
      if (gaps && (i % 256 == 0)) begin
        bus.saxis_tvalid = 1'b0;
        tick();
        if (state != 10'd2) bad++;
      end
      bus.saxis_tvalid = 1'b1;
      bus.saxis_tlast  = (i == tlast_pos);
      err_clear        = (i == clear_at);
      tick();
      err_clear = 1'b0;
      if (i < LEN - 1 && state != 10'd2) bad++;
      if (i == tlast_pos && i < LEN - 1) checkOutput("err_tlast_after_early_tlast", int'(err_tlast), 1);
    end
    bus.saxis_tvalid = 1'b0;
    bus.saxis_tlast  = 1'b0;
    checkOutput("input_state_held", bad, 0);
    if (n_beats == LEN) begin
      checkOutput("decode_start_state", int'(state), 4);
      checkOutput("decode_start_pulse", int'(bus.decode_start), 1);
      checkOutput("tready_low_after_input", int'(bus.saxis_tready), 0);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, int'(state), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_tready"}, int'(bus.saxis_tready), 0);
    checkOutput({tag, "_decode_start"}, int'(bus.decode_start), 0);
    checkOutput({tag, "_frame_count"}, int'(frame_count), 0);
    checkOutput({tag, "_err_tlast"}, int'(err_tlast), 0);
    checkOutput({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; enable = 1'b0; err_clear = 1'b0;
    bus.saxis_tvalid = 1'b0; bus.saxis_tlast = 1'b0; bus.decode_done = 1'b0;
    bus.maxis_tvalid = 1'b0; bus.maxis_tready = 1'b0; bus.maxis_tlast = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkResetValues("reset");

    // Frame A: clean frame, decoder done in the tenth cycle after launch.
    enable = 1'b1;
    tick();
    checkOutput("a_idle_to_input", int'(state), 2);
    checkOutput("a_tready", int'(bus.saxis_tready), 1);
    checkOutput("a_busy", int'(busy), 1);
    applyStimulus(LEN, LEN - 1, -1, 1'b1);
    tick();
    checkOutput("a_decode_state", int'(state), 8);
    checkOutput("a_decode_start_one_cycle", int'(bus.decode_start), 0);
    bad = 0;
    repeat (9) begin
      tick();
      if (state != 10'd8) bad++;
    end
    checkOutput("a_decode_held", bad, 0);
    bus.decode_done = 1'b1;
    tick();
    bus.decode_done = 1'b0;
    checkOutput("a_output_wait_1", int'(state), 256);
    tick();
    checkOutput("a_output_wait_2", int'(state), 256);
    tick();
    checkOutput("a_output", int'(state), 512);
    bus.maxis_tvalid = 1'b1; bus.maxis_tready = 1'b1; bus.maxis_tlast = 1'b1;
    tick();
    bus.maxis_tvalid = 1'b0; bus.maxis_tready = 1'b0; bus.maxis_tlast = 1'b0;
    checkOutput("a_back_to_input", int'(state), 2);
    checkOutput("a_frame_count", int'(frame_count), 1);
    checkOutput("a_err_tlast", int'(err_tlast), 0);
    checkOutput("a_err_timeout", int'(err_timeout), 0);

    // Frame B: tlast on beat 500, enable dropped in DECODE, output back-pressure.
    applyStimulus(LEN, 500, -1, 1'b0);
    checkOutput("b_err_tlast_sticky", int'(err_tlast), 1);
    tick();
    enable = 1'b0;
    repeat (2) tick();
    checkOutput("b_decode_after_enable_drop", int'(state), 8);
    bus.decode_done = 1'b1;
    tick();
    bus.decode_done = 1'b0;
    repeat (2) tick();
    checkOutput("b_output", int'(state), 512);
    bus.maxis_tvalid = 1'b1; bus.maxis_tlast = 1'b1; bus.maxis_tready = 1'b0;
    bad = 0;
    repeat (50) begin
      tick();
      if (state != 10'd512) bad++;
    end
    checkOutput("b_backpressure_hold", bad, 0);
    checkOutput("b_frame_count_held", int'(frame_count), 1);
    bus.maxis_tready = 1'b1;
    tick();
    bus.maxis_tvalid = 1'b0; bus.maxis_tready = 1'b0; bus.maxis_tlast = 1'b0;
    checkOutput("b_to_idle", int'(state), 1);
    checkOutput("b_busy_low", int'(busy), 0);
    checkOutput("b_frame_count", int'(frame_count), 2);
    tick();
    checkOutput("b_idle_stays", int'(state), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("clear_err_tlast", int'(err_tlast), 0);

    // Frame C: done only during DECODE_START, then decoder timeout.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checkOutput("c_input", int'(state), 2);
    applyStimulus(LEN, LEN - 1, -1, 1'b0);
    bus.decode_done = 1'b1;
    tick();
    bus.decode_done = 1'b0;
    checkOutput("c_done_ignored_in_start", int'(state), 8);
    bad = 0;
    repeat (15) begin
      tick();
      if (state != 10'd8 || err_timeout) bad++;
    end
    checkOutput("c_decode_16_cycles", bad, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("c_timeout_to_idle", int'(state), 1);
    checkOutput("c_err_timeout_set_beats_clear", int'(err_timeout), 1);
    checkOutput("c_frame_count_unchanged", int'(frame_count), 2);
    tick();
    checkOutput("c_err_timeout_sticky", int'(err_timeout), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("c_err_timeout_cleared", int'(err_timeout), 0);

    // Frame D: 300 beats with tlast+clear on beat 100, then reset mid-input.
    enable = 1'b1;
    tick();
    applyStimulus(300, 100, 100, 1'b0);
    checkOutput("d_err_tlast_held", int'(err_tlast), 1);
    reset = 1'b1;
    tick();
    checkResetValues("midreset");
    reset = 1'b0;
    tick();
    checkOutput("e_input", int'(state), 2);
    applyStimulus(LEN, LEN - 1, -1, 1'b0);
    tick();
    bus.decode_done = 1'b1;
    tick();
    bus.decode_done = 1'b0;
    enable = 1'b0;
    checkOutput("e_done_first_cycle", int'(state), 256);
    repeat (2) tick();
    bus.maxis_tvalid = 1'b1; bus.maxis_tready = 1'b1; bus.maxis_tlast = 1'b1;
    tick();
    bus.maxis_tvalid = 1'b0; bus.maxis_tready = 1'b0; bus.maxis_tlast = 1'b0;
    checkOutput("e_to_idle", int'(state), 1);
    checkOutput("e_frame_count", int'(frame_count), 1);
    checkOutput("e_err_tlast", int'(err_tlast), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
